muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer and HI/LO register owner for the MIPS core. It sits in the E stage, fed by the decoder's mult/multu/div/divu/mthi/mtlo classification. It models fixed-latency arithmetic and requests pipeline stalls while an HI/LO consumer waits. It also aborts in-flight operations on exception flush (CP0 path).

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage issue strobe for a HI/LO-writing instruction
op  input  3  MD_OP code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
a  input  32  rs operand (dividend / multiplicand / mthi/mtlo data)
b  input  32  rt operand (divisor / multiplier)
md_use  input  1  current E-stage instruction touches HI/LO (any mult/div/mthi/mtlo/mfhi/mflo)
cancel  input  1  exception flush; kills any in-flight op
busy  output  1  operation in progress
stall  output  1  pipeline stall request
done  output  1  one-cycle completion pulse
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-op): state=IDLE, counter=0, hi=lo=0, busy=stall=done=0.
- States: IDLE, BUSY. The counter is 5 bits wide.
- IDLE + start + op in {0..3} + !cancel: latch the pending result, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - The result may be computed combinationally from a/b at issue, or iteratively; either way it must be latched at issue.
- IDLE + start + op 4/5 + !cancel: write hi (op 4) or lo (op 5) from a at that edge; no busy, no done.
- IDLE + start + op 6/7: ignored.
- IDLE + start + cancel: ignored; the killed instruction has no effect.
- Timing: start sampled at edge k. busy=1 from edge k through edge k+N, i.e. exactly N cycles. At edge k+N: hi/lo written, busy drops, done=1 for that cycle only, state=IDLE.
- BUSY + start: ignored. The pipeline must not issue, which stall guarantees.
- BUSY + cancel: state=IDLE at the next edge. hi/lo retain their pre-op values; no done pulse.
- cancel on the completion edge: cancel wins; no write, no done.
- stall = md_use & busy (combinational). Stall is never asserted in IDLE.
- mult: signed 64-bit product; hi=[63:32], lo=[31:0]. multu: unsigned product, same split.
- div: lo=quotient truncated toward zero; hi=remainder with the dividend's sign. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b==0): full DIV_CYCLES latency and done pulse; hi/lo unchanged.
- done and busy are never high in the same cycle.

Decomposition:
- public.v gains MD_OP_MULT..MD_OP_MTLO defines and the MD_IDLE/MD_BUSY state encodings.
- One sub-module, muldiv_core, is natural. It is purely combinational: op, a, b -> 64-bit result plus a div_by_zero flag.
- muldiv_ctrl keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- multu a=0xFFFFFFFF b=2 -> busy for 5 cycles, then done; hi=0x00000001, lo=0xFFFFFFFE.
- mult a=-3 b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4. With md_use=1 held throughout, stall=1 for exactly 5 cycles.
- div a=-7 b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=0 with prior hi/lo=0x11/0x22 -> done after 10 cycles, hi/lo stay 0x11/0x22.
- mthi a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next edge, done=0. mtlo with start during BUSY -> lo unchanged.
- div started, cancel on busy cycle 3 -> busy=0 next edge, no done, hi/lo unchanged. cancel on the completion edge -> no write.
- reset pulsed asynchronously mid-mult -> hi=lo=0, busy=0 immediately. A following multu 3*5 -> lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared opcode and state encodings for the HI/LO
// multiply/divide sequencer, plus small opcode classification helpers.
package muldiv_ctrl_pkg;

  // MD_OP codes issued by the decoder
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  // Sequencer state encodings
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  localparam int unsigned MD_CNT_W = 5;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // mult/multu/div/divu all have op[2] clear
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: purely combinational arithmetic for the HI/LO sequencer.
// Ports:
//   op_i          MD_OP code (only 0..3 produce a result)
//   a_i, b_i      rs / rt operands
//   result_o      {hi, lo}: product split, or {remainder, quotient}
//   div_by_zero_o div/divu with b_i == 0
module muldiv_core
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_result_t  result_o,
  output logic        div_by_zero_o
);

  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] den;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn   = (op_i == MD_OP_MULT) || (op_i == MD_OP_DIV);
    ma    = sgn ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    mb    = sgn ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    // Low 64 bits of the extended product equal the exact signed/unsigned result
    prod  = ma * mb;

    // Signed divide works on magnitudes; |0x80000000| is still 0x80000000
    // as an unsigned value, so the overflow case falls out naturally.
    neg_a = sgn & a_i[31];
    neg_b = sgn & b_i[31];
    ua    = neg_a ? (32'd0 - a_i) : a_i;
    ub    = neg_b ? (32'd0 - b_i) : b_i;
    den   = (ub == '0) ? 32'd1 : ub;
    quo_mag = ua / den;
    rem_mag = ua % den;
    quo   = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
    rem   = neg_a ? (32'd0 - rem_mag) : rem_mag;

    div_by_zero_o = md_is_div(op_i) && (b_i == '0);

    result_o = '0;
    case (op_i)
      MD_OP_MULT, MD_OP_MULTU: result_o = md_result_t'(prod);
      MD_OP_DIV, MD_OP_DIVU: begin
        result_o.hi = rem;
        result_o.lo = quo;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: fixed-latency multiply/divide sequencer and HI/LO owner.
// Ports:
//   clk, reset     clock, async active-high reset
//   start, op      E-stage issue strobe and MD_OP code
//   a, b           rs / rt operands
//   md_use         E-stage instruction touches HI/LO
//   cancel         exception flush, kills in-flight op
//   busy, stall    op in progress / pipeline stall request (md_use & busy)
//   done           one-cycle completion pulse
//   hi, lo         architectural HI/LO registers
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [0:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  md_result_t          pend_q, pend_d;
  logic                pend_dz_q, pend_dz_d;
  logic                done_q, done_d;

  md_result_t          core_res;
  logic                core_dz;

  muldiv_core u_core (
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .result_o      (core_res),
    .div_by_zero_o (core_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    done_d    = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (start && !cancel) begin
          if (md_is_arith(op)) begin
            pend_d    = core_res;
            pend_dz_d = core_dz;
            cnt_d     = md_is_div(op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
            state_d   = MD_BUSY;
          end else if (op == MD_OP_MTHI) begin
            hi_d = a;
          end else if (op == MD_OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      MD_BUSY: begin
        // cancel takes priority even on the completion edge
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!pend_dz_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign stall = md_use & busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .md_use (md_use),
    .cancel (cancel),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected {hi,lo} on every completion pulse
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_and_busy", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        #1;
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy/stall cycles until done, bounded
  task automatic wait_done(input int unsigned lat, input string tag);
    int unsigned nb = 0;
    int unsigned ns = 0;
    bit got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) nb++;
      if (stall) ns++;
    end
    #2;
    if (!got) begin
      $display("FAIL timeout_%s: got no done want done", tag);
      vecs++;
      errs++;
    end
    chk({"busy_cycles_", tag}, nb, lat);
    chk({"stall_cycles_", tag}, ns, md_use ? lat : 0);
    chk({"sb_empty_", tag}, sb.size(), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] h, input logic [31:0] l, input logic [5:0] n);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.hi = h; v.lo = l; v.lat = n;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 6'd5);
    tbl[1]  = mk(3'd0, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, 6'd5);
    tbl[2]  = mk(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 6'd10);
    tbl[3]  = mk(3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 6'd10);
    tbl[4]  = mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 6'd10);
    tbl[5]  = mk(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 6'd5);
    tbl[6]  = mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6'd5);
    tbl[7]  = mk(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 6'd10);
    tbl[8]  = mk(3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 6'd10);
    tbl[9]  = mk(3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 6'd10);
    tbl[10] = mk(3'd4, 32'h11,       32'd0,        32'h00000011, 32'h00000002, 6'd0);
    tbl[11] = mk(3'd5, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 6'd0);
    tbl[12] = mk(3'd3, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 6'd10);
    tbl[13] = mk(3'd2, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 6'd10);
    tbl[14] = mk(3'd4, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h00000022, 6'd0);
    tbl[15] = mk(3'd6, 32'h123,      32'h456,      32'hDEADBEEF, 32'h00000022, 6'd0);
    tbl[16] = mk(3'd7, 32'h789,      32'hABC,      32'hDEADBEEF, 32'h00000022, 6'd0);

    reset  = 1'b1;
    start  = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    md_use = 1'b1;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'b0, busy},  32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      if (tbl[i].lat != 0) begin
        sb.push_back({tbl[i].hi, tbl[i].lo});
        wait_done(tbl[i].lat, $sformatf("v%0d", i));
      end else begin
        @(negedge clk);
        chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
        chk($sformatf("v%0d_done", i), {31'b0, done}, 32'd0);
        chk($sformatf("v%0d_hi", i), hi, tbl[i].hi);
        chk($sformatf("v%0d_lo", i), lo, tbl[i].lo);
      end
      chk($sformatf("v%0d_idle_stall", i), {31'b0, stall}, 32'd0);
    end

    // mtlo issued while busy is ignored
    issue(3'd0, 32'd2, 32'd3);
    sb.push_back({32'h0, 32'h6});
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'h0000FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, "mtlo_in_busy");
    repeat (2) @(negedge clk);
    chk("mtlo_in_busy_lo", lo, 32'h6);

    // cancel on busy cycle 3
    issue(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel3_busy", {31'b0, busy}, 32'd0);
    chk("cancel3_done", {31'b0, done}, 32'd0);
    chk("cancel3_hi", hi, 32'h0);
    chk("cancel3_lo", lo, 32'h6);
    repeat (12) @(negedge clk);
    chk("cancel3_lo_late", lo, 32'h6);

    // cancel on the completion edge
    issue(3'd0, 32'd4, 32'd4);
    repeat (5) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_last_busy", {31'b0, busy}, 32'd0);
    chk("cancel_last_done", {31'b0, done}, 32'd0);
    chk("cancel_last_lo", lo, 32'h6);

    // start with cancel in IDLE is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hAAAA5555; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_hi", hi, 32'h0);
    chk("cancel_idle_busy", {31'b0, busy}, 32'd0);

    // make hi nonzero, then async reset mid-mult
    issue(3'd4, 32'h5A5A5A5A, 32'd0);
    issue(3'd0, 32'd7, 32'd9);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_busy", {31'b0, busy}, 32'd0);
    chk("areset_hi", hi, 32'h0);
    chk("areset_lo", lo, 32'h0);
    #1;
    reset = 1'b0;
    issue(3'd1, 32'd3, 32'd5);
    sb.push_back({32'h0, 32'd15});
    wait_done(5, "post_reset");

    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
